// File: rtl/alu_pkg.sv
// Shared definitions for the alu_control_unit slice: opcode and alu_op
// constants, the ALU operation enum, the control bundle and the funct decoder.
// Optional feature macro: ALU_SHIFT_EN (enables sll/srl/sra decode).
package alu_pkg;

   // RISC-V major opcodes recognised by the main decoder
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_IARITH = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ    = 7'b1100011;

   // alu_op operation classes
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OP_IMM   = 2'b11;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_XOR  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_opcode_e;

   typedef struct packed {
      logic       alu_src;
      logic       mem_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   // Maps {funct7[5], funct3} to an ALU operation; unknown codes fall back to add
   function automatic alu_opcode_e decode_funct(input logic [3:0] bits);
      alu_opcode_e op;
      op = ALU_ADD;
      case (bits)
         4'b0000: op = ALU_ADD;
         4'b1000: op = ALU_SUB;
         4'b0111: op = ALU_AND;
         4'b0110: op = ALU_OR;
         4'b0100: op = ALU_XOR;
         4'b0010: op = ALU_SLT;
         4'b0011: op = ALU_SLTU;
`ifdef ALU_SHIFT_EN
         4'b0001: op = ALU_SLL;
         4'b0101: op = ALU_SRL;
         4'b1101: op = ALU_SRA;
`endif
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU, DATA_W wide (power of two, >= 8).
// Shift operations exist only when ALU_SHIFT_EN is defined; otherwise the
// shift encodings fall through to a zero result.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  alu_opcode_e       op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

`ifdef ALU_SHIFT_EN
   localparam int SHAMT_W = $clog2(DATA_W);
   logic [SHAMT_W-1:0] shamt;
   assign shamt = b[SHAMT_W-1:0];
`endif

   // Select the operation result; anything undefined yields zero
   always_comb begin
      // NOTE: default assignment first so every path drives result and no latch is inferred.
      result = '0;
      case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
`ifdef ALU_SHIFT_EN
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $signed(a) >>> shamt;
`endif
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_control_unit.sv
// Decode-and-execute slice: main control decode, ALU control decode and the
// ALU, with every output registered so each output set belongs to one
// sampled instruction. Optional feature macro: ALU_SHIFT_EN.
module alu_control_unit
   import alu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        opcode,
   input  logic [3:0]        instruction_bits,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              alu_src,
   output logic              mem_reg,
   output logic              reg_write,
   output logic              mem_read,
   output logic              mem_write,
   output logic              branch,
   output logic [1:0]        alu_op,
   output logic [3:0]        alu_opcodes,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              illegal
);

   ctrl_t             ctrl_next;
   alu_opcode_e       op_next;
   logic [DATA_W-1:0] result_next;

   // Main control: opcode to datapath control vector
   always_comb begin
      ctrl_next = '0;
      case (opcode)
         OPC_RTYPE:  ctrl_next = '{alu_src: 1'b0, mem_reg: 1'b0, reg_write: 1'b1, mem_read: 1'b0,
                                   mem_write: 1'b0, branch: 1'b0, alu_op: ALU_OP_FUNCT, illegal: 1'b0};
         OPC_IARITH: ctrl_next = '{alu_src: 1'b1, mem_reg: 1'b0, reg_write: 1'b1, mem_read: 1'b0,
                                   mem_write: 1'b0, branch: 1'b0, alu_op: ALU_OP_IMM, illegal: 1'b0};
         OPC_LOAD:   ctrl_next = '{alu_src: 1'b1, mem_reg: 1'b1, reg_write: 1'b1, mem_read: 1'b1,
                                   mem_write: 1'b0, branch: 1'b0, alu_op: ALU_OP_ADD, illegal: 1'b0};
         OPC_STORE:  ctrl_next = '{alu_src: 1'b1, mem_reg: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                                   mem_write: 1'b1, branch: 1'b0, alu_op: ALU_OP_ADD, illegal: 1'b0};
         OPC_BEQ:    ctrl_next = '{alu_src: 1'b0, mem_reg: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
                                   mem_write: 1'b0, branch: 1'b1, alu_op: ALU_OP_SUB, illegal: 1'b0};
         default:    ctrl_next.illegal = 1'b1;
      endcase
   end

   // ALU control: immediate forms ignore funct7[5] except for the srl/sra pair
   always_comb begin
      op_next = ALU_ADD;
      case (ctrl_next.alu_op)
         ALU_OP_ADD:   op_next = ALU_ADD;
         ALU_OP_SUB:   op_next = ALU_SUB;
         ALU_OP_FUNCT: op_next = decode_funct(instruction_bits);
         ALU_OP_IMM:   op_next = decode_funct((instruction_bits[2:0] == 3'b101) ? instruction_bits
                                              : {1'b0, instruction_bits[2:0]});
         default:      op_next = ALU_ADD;
      endcase
   end

   alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_next),
      .a      (a),
      .b      (b),
      .result (result_next)
   );

   // Output register stage with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all registered state so every output updates from the same pre-edge values.
      if (rst) begin
         alu_src     <= 1'b0;
         mem_reg     <= 1'b0;
         reg_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         branch      <= 1'b0;
         alu_op      <= ALU_OP_ADD;
         illegal     <= 1'b0;
         alu_opcodes <= ALU_ADD;
         result      <= '0;
         zero        <= 1'b1;
      end else begin
         alu_src     <= ctrl_next.alu_src;
         mem_reg     <= ctrl_next.mem_reg;
         reg_write   <= ctrl_next.reg_write;
         mem_read    <= ctrl_next.mem_read;
         mem_write   <= ctrl_next.mem_write;
         branch      <= ctrl_next.branch;
         alu_op      <= ctrl_next.alu_op;
         illegal     <= ctrl_next.illegal;
         alu_opcodes <= op_next;
         result      <= result_next;
         zero        <= (result_next == '0);
      end
   end

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit (DATA_W = 64). Expected outputs are
// pushed to a scoreboard when stimulus is driven and popped one edge later.
// Shift expectations follow the ALU_SHIFT_EN build setting.
`timescale 1ns/1ps
module tb_alu_control_unit;

   localparam int W = 64;

   // Control vector order: alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op[1:0], illegal
   localparam logic [8:0] C_R   = 9'b001000_10_0;
   localparam logic [8:0] C_I   = 9'b101000_11_0;
   localparam logic [8:0] C_LD  = 9'b111100_00_0;
   localparam logic [8:0] C_ST  = 9'b100010_00_0;
   localparam logic [8:0] C_BEQ = 9'b000001_01_0;
   localparam logic [8:0] C_ILL = 9'b000000_00_1;
   localparam logic [8:0] C_RST = 9'b000000_00_0;

   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    opcode;
   logic [3:0]    instruction_bits;
   logic [W-1:0]  a, b;
   logic          alu_src, mem_reg, reg_write, mem_read, mem_write, branch, zero, illegal;
   logic [1:0]    alu_op;
   logic [3:0]    alu_opcodes;
   logic [W-1:0]  result;

   typedef struct {
      string        name;
      logic [6:0]   op;
      logic [3:0]   bits;
      logic [W-1:0] av;
      logic [W-1:0] bv;
      logic         r;
      logic [8:0]   ctrl;
      logic [3:0]   aop;
      logic [W-1:0] res;
      logic         z;
   } step_t;

   step_t sb[$];
   int    checks   = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   alu_control_unit #(.DATA_W(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .opcode           (opcode),
      .instruction_bits (instruction_bits),
      .a                (a),
      .b                (b),
      .alu_src          (alu_src),
      .mem_reg          (mem_reg),
      .reg_write        (reg_write),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .branch           (branch),
      .alu_op           (alu_op),
      .alu_opcodes      (alu_opcodes),
      .result           (result),
      .zero             (zero),
      .illegal          (illegal)
   );

   function automatic step_t mk(input string name, input logic [6:0] op, input logic [3:0] bits,
                                input logic [W-1:0] av, input logic [W-1:0] bv, input logic r,
                                input logic [8:0] ctrl, input logic [3:0] aop, input logic [W-1:0] res);
      step_t s;
      s.name = name; s.op = op; s.bits = bits; s.av = av; s.bv = bv; s.r = r;
      s.ctrl = ctrl; s.aop = aop; s.res = res; s.z = (res == '0);
      return s;
   endfunction

   // Apply one instruction, record its expectation, and advance past the sampling edge
   task automatic drive(input step_t s);
      opcode = s.op; instruction_bits = s.bits; a = s.av; b = s.bv; rst = s.r;
      sb.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step_t e;
      drive(mk("reset", 7'b0110011, 4'b0000, 1, 2, 1'b1, C_RST, 4'b0010, 0));
      e = sb.pop_front();
      checks++;
      if ({alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal} !== e.ctrl) begin
         failures++;
         $display("FAIL %s ctrl got=%b want=%b", e.name,
                  {alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal}, e.ctrl);
      end
      checks++;
      if (alu_opcodes !== e.aop) begin
         failures++; $display("FAIL %s alu_opcodes got=%b want=%b", e.name, alu_opcodes, e.aop);
      end
      checks++;
      if (result !== e.res) begin
         failures++; $display("FAIL %s result got=%h want=%h", e.name, result, e.res);
      end
      checks++;
      if (zero !== e.z) begin
         failures++; $display("FAIL %s zero got=%b want=%b", e.name, zero, e.z);
      end
   endtask

   // Runs a list of back-to-back instructions, comparing each one edge after it is applied
   task automatic run_steps(input step_t steps[$]);
      step_t e;
      foreach (steps[i]) begin
         drive(steps[i]);
         e = sb.pop_front();
         checks++;
         if ({alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal} !== e.ctrl) begin
            failures++;
            $display("FAIL %s ctrl got=%b want=%b", e.name,
                     {alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal}, e.ctrl);
         end
         checks++;
         if (alu_opcodes !== e.aop) begin
            failures++; $display("FAIL %s alu_opcodes got=%b want=%b", e.name, alu_opcodes, e.aop);
         end
         checks++;
         if (result !== e.res) begin
            failures++; $display("FAIL %s result got=%h want=%h", e.name, result, e.res);
         end
         checks++;
         if (zero !== e.z) begin
            failures++; $display("FAIL %s zero got=%b want=%b", e.name, zero, e.z);
         end
      end
   endtask

   task automatic test_rtype();
      step_t s[$];
      s.push_back(mk("r_add",  7'b0110011, 4'b0000, 1, 2, 1'b0, C_R, 4'b0010, 3));
      s.push_back(mk("r_sub",  7'b0110011, 4'b1000, 1, 2, 1'b0, C_R, 4'b0110, ONES));
      s.push_back(mk("r_and",  7'b0110011, 4'b0111, 1, 2, 1'b0, C_R, 4'b0000, 0));
      s.push_back(mk("r_or",   7'b0110011, 4'b0110, 1, 2, 1'b0, C_R, 4'b0001, 3));
      s.push_back(mk("r_xor",  7'b0110011, 4'b0100, 6, 3, 1'b0, C_R, 4'b0011, 5));
      s.push_back(mk("r_slt",  7'b0110011, 4'b0010, 1, 2, 1'b0, C_R, 4'b1000, 1));
      s.push_back(mk("r_wrap", 7'b0110011, 4'b0000, ONES, 1, 1'b0, C_R, 4'b0010, 0));
      s.push_back(mk("r_undef_bits", 7'b0110011, 4'b1111, 1, 2, 1'b0, C_R, 4'b0010, 3));
      run_steps(s);
   endtask

   task automatic test_opcode_sweep();
      step_t s[$];
      s.push_back(mk("load",  7'b0000011, 4'b0111, 8, 4, 1'b0, C_LD,  4'b0010, 12));
      s.push_back(mk("store", 7'b0100011, 4'b1000, 8, 4, 1'b0, C_ST,  4'b0010, 12));
      s.push_back(mk("beq",   7'b1100011, 4'b0000, 5, 5, 1'b0, C_BEQ, 4'b0110, 0));
      s.push_back(mk("beq_ne", 7'b1100011, 4'b0000, 5, 7, 1'b0, C_BEQ, 4'b0110, ONES - 1));
      s.push_back(mk("illegal", 7'b1111111, 4'b1000, 1, 2, 1'b0, C_ILL, 4'b0010, 3));
      run_steps(s);
   endtask

   task automatic test_iarith();
      step_t s[$];
      s.push_back(mk("i_bit3_ignored", 7'b0010011, 4'b1000, 5, 2, 1'b0, C_I, 4'b0010, 7));
      s.push_back(mk("i_and",          7'b0010011, 4'b1111, 5, 3, 1'b0, C_I, 4'b0000, 1));
      s.push_back(mk("i_sltu",         7'b0010011, 4'b1011, 1, 2, 1'b0, C_I, 4'b1001, 1));
      run_steps(s);
   endtask

   task automatic test_shift_compare();
      step_t s[$];
`ifdef ALU_SHIFT_EN
      s.push_back(mk("sra",      7'b0110011, 4'b1101, MSB, 1, 1'b0, C_R, 4'b0111, {2'b11, {(W-2){1'b0}}}));
      s.push_back(mk("srl",      7'b0110011, 4'b0101, MSB, 1, 1'b0, C_R, 4'b0101, {2'b01, {(W-2){1'b0}}}));
      s.push_back(mk("sll",      7'b0110011, 4'b0001, 1, 2, 1'b0, C_R, 4'b0100, 4));
      s.push_back(mk("sra_shamt_mask", 7'b0110011, 4'b1101, MSB, W + 1, 1'b0, C_R, 4'b0111, {2'b11, {(W-2){1'b0}}}));
      s.push_back(mk("i_srai",   7'b0010011, 4'b1101, MSB, 1, 1'b0, C_I, 4'b0111, {2'b11, {(W-2){1'b0}}}));
`else
      s.push_back(mk("sra_as_add", 7'b0110011, 4'b1101, MSB, 1, 1'b0, C_R, 4'b0010, MSB + 1));
      s.push_back(mk("srl_as_add", 7'b0110011, 4'b0101, MSB, 1, 1'b0, C_R, 4'b0010, MSB + 1));
      s.push_back(mk("sll_as_add", 7'b0110011, 4'b0001, 1, 2, 1'b0, C_R, 4'b0010, 3));
`endif
      s.push_back(mk("slt_neg",  7'b0110011, 4'b0010, ONES, 0, 1'b0, C_R, 4'b1000, 1));
      s.push_back(mk("sltu_neg", 7'b0110011, 4'b0011, ONES, 0, 1'b0, C_R, 4'b1001, 0));
      run_steps(s);
   endtask

   task automatic test_reset_midstream();
      step_t s[$];
      s.push_back(mk("pre_rst",  7'b0110011, 4'b0000, 1, 2, 1'b0, C_R,   4'b0010, 3));
      s.push_back(mk("mid_rst",  7'b0110011, 4'b1000, 1, 2, 1'b1, C_RST, 4'b0010, 0));
      s.push_back(mk("post_rst", 7'b0110011, 4'b1000, 1, 2, 1'b0, C_R,   4'b0110, ONES));
      run_steps(s);
   endtask

   initial begin
      rst = 1'b1; opcode = '0; instruction_bits = '0; a = '0; b = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_rtype();
      test_opcode_sweep();
      test_iarith();
      test_shift_compare();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Combined decode-and-execute slice of the RISC-V datapath. It merges three functions: the main control unit (opcode to datapath control signals), ALU control (alu_op plus instruction bits to a 4-bit ALU operation code) and the ALU itself. All outputs are registered, so every outputs set is coherent and belongs to the same sampled instruction.

## Interface
- DATA_W, 64, operand and result width; must be a power of two, at least 8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0].
- instruction_bits  in  4  {instruction[30], instruction[14:12]} (funct7 bit 5, funct3).
- a  in  DATA_W  operand A (rs1).
- b  in  DATA_W  operand B (rs2 or immediate, as already selected by the datapath).
- alu_src, mem_reg, reg_write, mem_read, mem_write, branch  out  1 each  datapath control signals.
- alu_op  out  2  ALU operation class.
- alu_opcodes  out  4  decoded ALU operation.
- result  out  DATA_W  ALU result.
- zero  out  1  result equals 0.
- illegal  out  1  opcode not recognised.

## Operation
Main decode. Each line gives alu_src, mem_reg, reg_write, mem_read, mem_write, branch, alu_op:
- 0110011 R-type: 0,0,1,0,0,0,10.
- 0010011 I-arith: 1,0,1,0,0,0,11.
- 0000011 load: 1,1,1,1,0,0,00.
- 0100011 store: 1,0,0,0,1,0,00.
- 1100011 beq: 0,0,0,0,0,1,01.
- Any other opcode: all signals 0, alu_op 00, illegal 1.

ALU control:
- alu_op 00 gives add.
- alu_op 01 gives sub.
- alu_op 10 decodes instruction_bits in full.
- alu_op 11 decodes with bit 3 forced to 0, except that funct3 101 keeps bit 3 (selects srl or sra).

instruction_bits to alu_opcodes:
- 0000 add: 0010.
- 1000 sub: 0110.
- 0111 and: 0000.
- 0110 or: 0001.
- 0100 xor: 0011.
- 0010 slt: 1000.
- 0011 sltu: 1001.
- 0001 sll: 0100.
- 0101 srl: 0101.
- 1101 sra: 0111.
- Any other code: add (0010).

ALU:
- Add and sub wrap modulo 2^DATA_W; no carry or overflow output.
- slt is a signed compare and sltu an unsigned compare; both produce 0 or 1 zero-extended.
- Shift amount is b[log2(DATA_W)-1:0]; sra replicates a[DATA_W-1].
- Undefined alu_opcodes values produce result 0.
- zero = (result == 0).

## Timing
- All outputs are registered on the rising edge of clk. Latency is 1 cycle from the sampled opcode, instruction_bits, a and b.
- The ALU uses the alu_opcodes decoded from the same-cycle inputs, so no pipeline skew exists between outputs.
- Reset (rst high at a clock edge):
  - All control outputs 0, alu_op 00, illegal 0.
  - alu_opcodes 0010.
  - result 0, zero 1.
- Reset overrides any input on the same edge. The first valid output appears one edge after rst is deasserted.
- No handshake: a new instruction is accepted every cycle.

## Configuration
- ALU_SHIFT_EN defined: sll, srl and sra are decoded and executed as specified.
- ALU_SHIFT_EN undefined:
  - Shift encodings decode to add (0010).
  - Shift hardware is omitted.
  - alu_opcodes 0100, 0101 and 0111 produce result 0.

## Structure
- Shared package alu_pkg holds:
  - Opcode constants.
  - alu_op class constants.
  - The 4-bit alu_opcodes enum (AND, OR, ADD, XOR, SLL, SRL, SUB, SRA, SLT, SLTU).
- One sub-module, alu (combinational, DATA_W-parameterised). Control and ALU-control decode live in the top module, followed by the output register stage.

## Test plan
- opcode 0110011, a=1, b=2:
  - instruction_bits 0000: result 3, alu_opcodes 0010.
  - 1000: result all ones (-1), alu_opcodes 0110.
  - 0111: result 0, zero 1.
  - 0110: result 3.
  - Each result appears one cycle after its inputs are applied.
- Opcode sweep over 0000011, 0100011 and 1100011:
  - Control vectors match the table.
  - beq with a=b=5 gives result 0 and zero 1.
  - Load with a=8, b=4 gives result 12.
- Unknown opcode 1111111: all control signals 0, illegal 1.
- I-arith (0010011), instruction_bits 1000, a=5, b=2: bit 3 is ignored, so result 7 (add).
- Shifts with ALU_SHIFT_EN defined:
  - a=0x80..0 (MSB set), b=1, sra: result 0xC0..0.
  - srl: result 0x40..0.
  - slt with a=-1, b=0 gives 1; sltu with the same operands gives 0.
- Assert rst mid-stream with opcode R-type, a=1, b=2: the next edge shows all outputs at reset values (result 0, zero 1, alu_opcodes 0010).
